// File: rtl/svunit_check_pkg.sv
// svunit_check_pkg: shared types and helpers for the SVUnit check collector.
// Holds the collector FSM encoding, the verdict encoding, the failure record
// layout and a population-count helper used by the event counters.
package svunit_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } collector_state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } check_status_t;

  // Record layout at the default configuration (4 channels, 8-bit IDs).
  // The collector packs the same {ch, id} order at its parameterised widths.
  localparam int REC_CH_W = 2;
  localparam int REC_ID_W = 8;

  typedef struct packed {
    logic [REC_CH_W-1:0] ch;
    logic [REC_ID_W-1:0] id;
  } fail_rec_t;

  // Widest event vector the popcount helper handles.
  localparam int POP_MAX_W = 32;

  function automatic logic [5:0] popcount(input logic [POP_MAX_W-1:0] vec);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      cnt = cnt + {5'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/svunit_check_fifo.sv
// svunit_check_fifo: synchronous fall-through FIFO for failure records.
// Head data is visible on dout_o whenever empty_o is low. A push presented
// while full is accepted only if a pop happens in the same cycle. clr_i
// flushes the contents and takes priority over push and pop.
module svunit_check_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Status flags, head data and the qualified push/pop strobes.
  always_comb begin
    full_o    = (count_q == CNT_W'(DEPTH));
    empty_o   = (count_q == {CNT_W{1'b0}});
    dout_o    = mem_q[rd_ptr_q];
    do_pop_s  = pop_i && !empty_o;
    do_push_s = push_i && (!full_o || do_pop_s);
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    if (clr_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = do_pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s && !clr_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/svunit_check_collector.sv
// svunit_check_collector: multi-channel pass/fail check collector.
// Counts accepted check events with saturating tallies, queues the
// lowest-index failing {channel, id} per cycle and registers a verdict
// when the test ends. Optional watchdog: define SVUNIT_CHECK_TIMEOUT_EN.
module svunit_check_collector
  import svunit_check_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int ID_W        = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic                             stop_i,
  input  logic [NUM_CH-1:0]                chk_valid_i,
  output logic [NUM_CH-1:0]                chk_ready_o,
  input  logic [NUM_CH-1:0]                chk_pass_i,
  input  logic [NUM_CH*ID_W-1:0]           chk_id_i,
  output logic [CNT_W-1:0]                 pass_cnt_o,
  output logic [CNT_W-1:0]                 fail_cnt_o,
  output logic                             fail_valid_o,
  input  logic                             fail_ready_i,
  output logic [ID_W+$clog2(NUM_CH)-1:0]   fail_rec_o,
  output logic                             fail_drop_o,
  output logic [1:0]                       state_o,
  output logic                             done_o,
  output logic [1:0]                       status_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int IDX_W = (CH_W > 0) ? CH_W : 1;
  localparam int REC_W = ID_W + CH_W;
  // Sum width leaves headroom for a 6-bit popcount so saturation is exact.
  localparam int SUM_W = CNT_W + 7;
  localparam logic [SUM_W-1:0] CNT_MAX = {{7{1'b0}}, {CNT_W{1'b1}}};

  collector_state_t state_q, state_d;
  check_status_t    status_q, status_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             fail_drop_q, fail_drop_d;

  logic              run_s, clear_s, enter_report_s, timeout_s;
  logic [NUM_CH-1:0] acc_vec_s, pass_vec_s, fail_vec_s;
  logic [5:0]        pass_inc_s, fail_inc_s;
  logic [SUM_W-1:0]  pass_sum_s, fail_sum_s;
  logic [IDX_W-1:0]  fail_idx_s;
  logic [ID_W-1:0]   fail_id_s;
  logic [REC_W-1:0]  push_rec_s;
  logic              push_s, pop_s, multi_fail_s, drop_s;
  logic              fifo_full_s, fifo_empty_s;

  // Next-state logic: stop (or watchdog expiry) ends RUN, start wins elsewhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? RUN : IDLE;
      RUN:     state_d = (stop_i || timeout_s) ? REPORT : RUN;
      REPORT:  state_d = start_i ? RUN : REPORT;
      default: state_d = IDLE;
    endcase
  end

  // Transition strobes and per-channel event classification.
  always_comb begin
    run_s          = (state_q == RUN);
    clear_s        = (state_q != RUN) && (state_d == RUN);
    enter_report_s = run_s && (state_d == REPORT);
    acc_vec_s      = run_s ? chk_valid_i : {NUM_CH{1'b0}};
    pass_vec_s     = acc_vec_s & chk_pass_i;
    fail_vec_s     = acc_vec_s & ~chk_pass_i;
    pass_inc_s     = popcount(32'(pass_vec_s));
    fail_inc_s     = popcount(32'(fail_vec_s));
    pass_sum_s     = {{(SUM_W-CNT_W){1'b0}}, pass_cnt_q} + {{(SUM_W-6){1'b0}}, pass_inc_s};
    fail_sum_s     = {{(SUM_W-CNT_W){1'b0}}, fail_cnt_q} + {{(SUM_W-6){1'b0}}, fail_inc_s};
  end

  // Pick the lowest-index failing channel; scanning downward lets it win.
  always_comb begin
    fail_idx_s = {IDX_W{1'b0}};
    fail_id_s  = {ID_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fail_vec_s[i]) begin
        fail_idx_s = IDX_W'(i);
        fail_id_s  = chk_id_i[i*ID_W +: ID_W];
      end else begin
        fail_idx_s = fail_idx_s;
        fail_id_s  = fail_id_s;
      end
    end
  end

  if (CH_W > 0) begin : g_rec_ch
    assign push_rec_s = {fail_idx_s, fail_id_s};
  end else begin : g_rec_noch
    assign push_rec_s = fail_id_s;
  end

  // FIFO handshake and drop detection (extra failures or push into a full FIFO).
  always_comb begin
    push_s       = |fail_vec_s;
    pop_s        = fail_ready_i && !fifo_empty_s;
    multi_fail_s = |(fail_vec_s & (fail_vec_s - NUM_CH'(1)));
    drop_s       = multi_fail_s || (push_s && fifo_full_s && !pop_s);
  end

  // Saturating tallies and the sticky drop flag.
  always_comb begin
    if (clear_s) begin
      pass_cnt_d  = {CNT_W{1'b0}};
      fail_cnt_d  = {CNT_W{1'b0}};
      fail_drop_d = 1'b0;
    end else if (run_s) begin
      pass_cnt_d  = (pass_sum_s > CNT_MAX) ? {CNT_W{1'b1}} : pass_sum_s[CNT_W-1:0];
      fail_cnt_d  = (fail_sum_s > CNT_MAX) ? {CNT_W{1'b1}} : fail_sum_s[CNT_W-1:0];
      fail_drop_d = fail_drop_q | drop_s;
    end else begin
      pass_cnt_d  = pass_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      fail_drop_d = fail_drop_q;
    end
  end

  // Verdict captured on REPORT entry, including events of the final RUN cycle.
  always_comb begin
    if (clear_s) begin
      status_d = NONE;
    end else if (enter_report_s) begin
      if (timeout_s) begin
        status_d = TIMEOUT;
      end else if ((fail_cnt_d != {CNT_W{1'b0}}) || fail_drop_d) begin
        status_d = FAIL;
      end else begin
        status_d = PASS;
      end
    end else begin
      status_d = status_q;
    end
  end

`ifdef SVUNIT_CHECK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            any_acc_s;

  // Idle-cycle watchdog: expiry is the cycle whose increment reaches TIMEOUT_CYC.
  always_comb begin
    any_acc_s = |acc_vec_s;
    timeout_s = run_s && !any_acc_s && (wdog_q == WD_LAST);
    if (clear_s) begin
      wdog_d = {WD_W{1'b0}};
    end else if (run_s) begin
      wdog_d = any_acc_s ? {WD_W{1'b0}} : (wdog_q + WD_W'(1));
    end else begin
      wdog_d = wdog_q;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= {WD_W{1'b0}};
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Collector state, counters, drop flag and verdict registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      status_q    <= NONE;
      pass_cnt_q  <= {CNT_W{1'b0}};
      fail_cnt_q  <= {CNT_W{1'b0}};
      fail_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_drop_q <= fail_drop_d;
    end
  end

  svunit_check_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fail_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clear_s),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (push_rec_s),
    .dout_o  (fail_rec_o),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Output decode; everything is driven from registered state.
  always_comb begin
    chk_ready_o  = run_s ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};
    done_o       = (state_q == REPORT);
    state_o      = state_q;
    status_o     = status_q;
    pass_cnt_o   = pass_cnt_q;
    fail_cnt_o   = fail_cnt_q;
    fail_drop_o  = fail_drop_q;
    fail_valid_o = !fifo_empty_s;
  end

endmodule
